// File: rtl/pingpong_frame_buffer_pkg.sv
// rtl/pingpong_frame_buffer_pkg.sv - shared frame sizes and read-FSM encoding
package pingpong_frame_buffer_pkg;

  localparam int ADDRLENGTH = 12;
  localparam int DATAWIDTH  = 32;
  localparam int FRAME_LEN  = 1 << ADDRLENGTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bank_ram.sv
// rtl/bank_ram.sv - simple dual-port RAM holding both frame banks; bank select is the address MSB
module bank_ram
  import pingpong_frame_buffer_pkg::*;
#(
  parameter int AW = ADDRLENGTH + 1,
  parameter int DW = DATAWIDTH
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// rtl/pingpong_frame_buffer.sv - two-bank frame buffer: linear fill, permuted read-back driven by the
// address accumulator
module pingpong_frame_buffer
  import pingpong_frame_buffer_pkg::rd_state_t,
         pingpong_frame_buffer_pkg::IDLE,
         pingpong_frame_buffer_pkg::RUN;
#(
  parameter int ADDRLENGTH = pingpong_frame_buffer_pkg::ADDRLENGTH,
  parameter int DATAWIDTH  = pingpong_frame_buffer_pkg::DATAWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATAWIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  acc_enable,
  input  logic [ADDRLENGTH-1:0] rd_addr,
  output logic                  out_valid,
  output logic [DATAWIDTH-1:0]  out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  ovf
);

  rd_state_t             state, state_n;
  logic                  wb, rb, rb_d;
  logic [1:0]            full, full_n;
  logic [ADDRLENGTH-1:0] wr_ptr, rd_cnt;
  logic                  accept, wr_done, rd_last, other_full;
  logic                  rd_en_d, sof_d, eof_d;
  logic [DATAWIDTH-1:0]  ram_q;

  assign in_ready = !full[wb];
  assign accept   = in_valid && in_ready;
  assign wr_done  = accept && (wr_ptr == '1);
  assign rd_last  = (state == RUN) && (rd_cnt == '1);
  // A bank completing on this very edge counts as full, so back-to-back frames read with no gap.
  assign other_full = full[!rb] || (wr_done && (wb != rb));

  always_comb begin
    state_n    = state;
    full_n     = full;
    acc_enable = 1'b0;
    if (wr_done) begin
      full_n[wb] = 1'b1;
    end
    case (state)
      IDLE: begin
        if (full[rb]) begin
          state_n = RUN;
        end
      end
      RUN: begin
        acc_enable = 1'b1;
        if (rd_last) begin
          full_n[rb] = 1'b0;
          if (!other_full) begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wb        <= 1'b0;
      rb        <= 1'b0;
      rb_d      <= 1'b0;
      full      <= 2'b00;
      wr_ptr    <= '0;
      rd_cnt    <= '0;
      ovf       <= 1'b0;
      rd_en_d   <= 1'b0;
      sof_d     <= 1'b0;
      eof_d     <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      state <= state_n;
      full  <= full_n;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wr_done) begin
        wb <= !wb;
      end
      if (rd_last) begin
        rb <= !rb;
      end
      rd_cnt <= acc_enable ? rd_cnt + 1'b1 : '0;
      if (in_valid && !in_ready) begin
        ovf <= 1'b1;
      end
      // The accumulator steps on the edge that samples acc_enable, so the RAM read waits one cycle.
      rd_en_d   <= acc_enable;
      rb_d      <= rb;
      sof_d     <= acc_enable && (rd_cnt == '0);
      eof_d     <= rd_last;
      out_valid <= rd_en_d;
      out_sof   <= sof_d;
      out_eof   <= eof_d;
    end
  end

  bank_ram #(
    .AW(ADDRLENGTH + 1),
    .DW(DATAWIDTH)
  ) u_bank_ram (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr({wb, wr_ptr}),
    .wr_data(in_data),
    .rd_en  (rd_en_d),
    .rd_addr({rb_d, rd_addr}),
    .rd_data(ram_q)
  );

  assign out_data = out_valid ? ram_q : '0;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// tb/tb_pingpong_frame_buffer.sv - directed self-checking bench for pingpong_frame_buffer
module tb_pingpong_frame_buffer;
  import pingpong_frame_buffer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DATAWIDTH-1:0]  in_data = '0;
  logic                  in_ready, acc_enable, out_valid, out_sof, out_eof, ovf;
  logic [ADDRLENGTH-1:0] rd_addr;
  logic [DATAWIDTH-1:0]  out_data;

  logic [ADDRLENGTH-1:0] acc;
  bit                    perm = 1'b0;
  int                    checks = 0;
  int                    errors = 0;

  logic [DATAWIDTH-1:0]  oq[$];
  bit                    sq[$];
  bit                    eq[$];
  int                    en_cnt = 0;
  int                    gap_cnt = 0;
  int                    ready_low = 0;
  int                    expect_n = 0;
  bit                    started = 1'b0;

  always #5 clk = ~clk;

  pingpong_frame_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .acc_enable(acc_enable),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .ovf       (ovf)
  );

  function automatic logic [11:0] digit_reverse(input logic [11:0] a);
    logic [11:0] r;
    for (int d = 0; d < 6; d++) begin
      r[2*d +: 2] = a[2*(5-d) +: 2];
    end
    return r;
  endfunction

  // Behavioural accumulator: resets to -1, steps on the edge that samples acc_enable.
  always @(posedge clk or negedge rst) begin
    if (!rst) acc <= '1;
    else if (acc_enable) acc <= acc + 1'b1;
  end
  assign rd_addr = perm ? digit_reverse(acc) : acc;

  always @(negedge clk) begin
    if (rst) begin
      if (acc_enable) en_cnt++;
      if (!in_ready) ready_low++;
      if (out_valid) begin
        oq.push_back(out_data);
        sq.push_back(out_sof);
        eq.push_back(out_eof);
        started = 1'b1;
      end else if (started && oq.size() < expect_n) begin
        gap_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    oq.delete();
    sq.delete();
    eq.delete();
    en_cnt = 0;
    gap_cnt = 0;
    ready_low = 0;
    started = 1'b0;
    expect_n = n;
    #1 rst = 1'b1;
  endtask

  task automatic send(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = base + 32'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int cyc = 0;
    while (oq.size() < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 64'(oq.size()), 64'(n));
  endtask

  task automatic check_frame(input string tag, input int first, input logic [31:0] base, input bit p);
    for (int i = 0; i < FRAME_LEN; i++) begin
      int j = first + i;
      logic [31:0] exp;
      exp = base + (p ? 32'(digit_reverse(12'(i))) : 32'(i));
      if (j < oq.size()) begin
        check($sformatf("%s_data[%0d]", tag, i), 64'(oq[j]), 64'(exp));
        check($sformatf("%s_sof[%0d]", tag, i), 64'(sq[j]), 64'(i == 0));
        check($sformatf("%s_eof[%0d]", tag, i), 64'(eq[j]), 64'(i == FRAME_LEN - 1));
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_acc_enable", 64'(acc_enable), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sof", 64'(out_sof), 64'd0);
    check("rst_out_eof", 64'(out_eof), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    // Single frame, linear read, with fill-to-read and read latency
    perm = 1'b0;
    do_reset(FRAME_LEN);
    send(32'd0, FRAME_LEN);
    check("fill_acc_idle", 64'(acc_enable), 64'd0);
    @(posedge clk); #1;
    check("fill_acc_on", 64'(acc_enable), 64'd1);
    check("lat_valid_k", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid_k1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid_k2", 64'(out_valid), 64'd1);
    check("lat_sof_k2", 64'(out_sof), 64'd1);
    check("lat_data_k2", 64'(out_data), 64'd0);
    wait_out("single", FRAME_LEN);
    check("single_enables", 64'(en_cnt), 64'(FRAME_LEN));
    check("single_gap", 64'(gap_cnt), 64'd0);
    check_frame("single", 0, 32'd0, 1'b0);

    // Permuted read with 2-bit digit-reversed addresses
    perm = 1'b1;
    do_reset(FRAME_LEN);
    send(32'd0, FRAME_LEN);
    wait_out("perm", FRAME_LEN);
    if (oq.size() > 4) begin
      check("perm_out1", 64'(oq[1]), 64'd1024);
      check("perm_out4", 64'(oq[4]), 64'd256);
    end
    check_frame("perm", 0, 32'd0, 1'b1);
    perm = 1'b0;

    // Continuous streaming; a one-cycle input slip aligns each last write with the last read
    do_reset(3 * FRAME_LEN);
    send(32'h0, FRAME_LEN);
    @(posedge clk); #1;
    send(32'h10000, FRAME_LEN);
    check("sim_in_ready", 64'(in_ready), 64'd1);
    check("sim_acc_enable", 64'(acc_enable), 64'd1);
    send(32'h20000, FRAME_LEN);
    wait_out("stream", 3 * FRAME_LEN);
    if (oq.size() > FRAME_LEN) check("stream_f2_first", 64'(oq[FRAME_LEN]), 64'h10000);
    check("stream_gap", 64'(gap_cnt), 64'd0);
    check("stream_ready_low", 64'(ready_low), 64'd0);
    check("stream_ovf", 64'(ovf), 64'd0);
    check("stream_enables", 64'(en_cnt), 64'(3 * FRAME_LEN));
    check_frame("stream_f1", 0, 32'h0, 1'b0);
    check_frame("stream_f2", FRAME_LEN, 32'h10000, 1'b0);
    check_frame("stream_f3", 2 * FRAME_LEN, 32'h20000, 1'b0);

    // Overrun: 8193 back-to-back samples, the last lands while both banks are full
    do_reset(2 * FRAME_LEN);
    send(32'h0, 2 * FRAME_LEN);
    check("ovr_ready_low", 64'(in_ready), 64'd0);
    check("ovr_ovf_before", 64'(ovf), 64'd0);
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ovr_ovf_set", 64'(ovf), 64'd1);
    check("ovr_ready_back", 64'(in_ready), 64'd1);
    wait_out("ovr", 2 * FRAME_LEN);
    check("ovr_gap", 64'(gap_cnt), 64'd0);
    check("ovr_ovf_sticky", 64'(ovf), 64'd1);
    check_frame("ovr_f1", 0, 32'h0, 1'b0);
    check_frame("ovr_f2", FRAME_LEN, 32'h1000, 1'b0);

    // Reset at output sample 1000, then a clean frame
    do_reset(FRAME_LEN);
    send(32'h30000, FRAME_LEN);
    begin
      int cyc = 0;
      while (oq.size() < 1000 && cyc < 10000) begin
        @(negedge clk);
        cyc++;
      end
      check("mid_reached", 64'(oq.size() >= 1000), 64'd1);
    end
    #1 rst = 1'b0;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_out_data", 64'(out_data), 64'd0);
    check("mid_out_sof", 64'(out_sof), 64'd0);
    check("mid_out_eof", 64'(out_eof), 64'd0);
    check("mid_acc_enable", 64'(acc_enable), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd1);
    do_reset(FRAME_LEN);
    send(32'h40000, FRAME_LEN);
    wait_out("after_rst", FRAME_LEN);
    if (oq.size() > 0) check("after_rst_first", 64'(oq[0]), 64'h40000);
    check_frame("after_rst", 0, 32'h40000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
